// File: rtl/imul_iter_ctrl.sv
// Control FSM for the iterative shift-add multiplier: sequences operand load,
// one shift-add step per cycle, and the val/rdy handshake on both streams.
`timescale 1ns/1ps

module imul_iter_ctrl #(
    parameter int unsigned p_nbits      = 32,
    parameter bit          p_early_exit = 1'b0
) (
    input  logic clk,
    input  logic reset,

    input  logic istream_val,
    output logic istream_rdy,
    output logic ostream_val,
    input  logic ostream_rdy,

    input  logic b_lsb,
    input  logic b_zero,

    output logic a_mux_sel,
    output logic b_mux_sel,
    output logic result_mux_sel,
    output logic a_en,
    output logic b_en,
    output logic result_en
);

    localparam int unsigned      CW   = $clog2(p_nbits) + 1;
    localparam logic [CW-1:0]    LAST = CW'(p_nbits - 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] count_q, count_d;

    // Moore outputs are registered from the next state so they change with it.
    logic rdy_q,  rdy_d;
    logic oval_q, oval_d;
    logic ld_q,   ld_d;
    logic en_q,   en_d;
    logic calc_q, calc_d;

    always_comb begin
        state_d = state_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (istream_val) begin
                    state_d = CALC;
                    count_d = '0;
                end
            end
            CALC: begin
                if ((count_q == LAST) || (p_early_exit && b_zero)) begin
                    state_d = DONE;
                    count_d = '0;
                end else begin
                    count_d = count_q + CW'(1);
                end
            end
            DONE: begin
                if (ostream_rdy) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        rdy_d  = (state_d == IDLE);
        oval_d = (state_d == DONE);
        ld_d   = (state_d == IDLE);
        en_d   = (state_d != DONE);
        calc_d = (state_d == CALC);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            count_q <= '0;
            rdy_q   <= 1'b1;
            oval_q  <= 1'b0;
            ld_q    <= 1'b1;
            en_q    <= 1'b1;
            calc_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            rdy_q   <= rdy_d;
            oval_q  <= oval_d;
            ld_q    <= ld_d;
            en_q    <= en_d;
            calc_q  <= calc_d;
        end
    end

    // b_lsb only reaches result_en while calculating, so X elsewhere is masked.
    always_comb begin
        istream_rdy    = rdy_q  & ~reset;
        ostream_val    = oval_q & ~reset;
        a_en           = en_q   & ~reset;
        b_en           = en_q   & ~reset;
        a_mux_sel      = ld_q;
        b_mux_sel      = ld_q;
        result_mux_sel = ld_q;
        result_en      = 1'b0;
        if (!reset) begin
            if (calc_q) result_en = b_lsb;
            else        result_en = ld_q;
        end
    end

endmodule

// File: tb/tb_imul_iter_ctrl.sv
// Bench for imul_iter_ctrl: fixed-latency and early-exit instances share the
// stimulus; a transaction-level model is compared every cycle, plus literal checks.
`timescale 1ns/1ps

module tb_imul_iter_ctrl;

    localparam int unsigned NB = 32;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic istream_val = 1'b0;
    logic ostream_rdy = 1'b0;
    logic b_lsb = 1'b0;
    logic b_zero = 1'b0;

    logic [1:0] irdy, oval, asel, bsel, rsel, aen, ben, ren;

    int n_checks = 0;
    int n_pass   = 0;
    int cyc      = 0;

    always #5 clk = ~clk;

    imul_iter_ctrl #(.p_nbits(NB), .p_early_exit(1'b0)) dut_fix (
        .clk(clk), .reset(reset),
        .istream_val(istream_val), .istream_rdy(irdy[0]),
        .ostream_val(oval[0]), .ostream_rdy(ostream_rdy),
        .b_lsb(b_lsb), .b_zero(b_zero),
        .a_mux_sel(asel[0]), .b_mux_sel(bsel[0]), .result_mux_sel(rsel[0]),
        .a_en(aen[0]), .b_en(ben[0]), .result_en(ren[0])
    );

    imul_iter_ctrl #(.p_nbits(NB), .p_early_exit(1'b1)) dut_ee (
        .clk(clk), .reset(reset),
        .istream_val(istream_val), .istream_rdy(irdy[1]),
        .ostream_val(oval[1]), .ostream_rdy(ostream_rdy),
        .b_lsb(b_lsb), .b_zero(b_zero),
        .a_mux_sel(asel[1]), .b_mux_sel(bsel[1]), .result_mux_sel(rsel[1]),
        .a_en(aen[1]), .b_en(ben[1]), .result_en(ren[1])
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Transaction model: a job is either waiting to be accepted, running a
    // number of shift-add iterations, or holding its product for the consumer.
    bit m_busy[2];
    bit m_done[2];
    int m_iter[2];

    always @(posedge clk) begin
        cyc++;
        for (int i = 0; i < 2; i++) begin
            if (reset) begin
                m_busy[i] = 1'b0;
                m_done[i] = 1'b0;
                m_iter[i] = 0;
            end else if (m_done[i]) begin
                if (ostream_rdy) m_done[i] = 1'b0;
            end else if (m_busy[i]) begin
                m_iter[i]++;
                if (m_iter[i] == NB || (i == 1 && b_zero === 1'b1)) begin
                    m_busy[i] = 1'b0;
                    m_done[i] = 1'b1;
                end
            end else if (istream_val) begin
                m_busy[i] = 1'b1;
                m_iter[i] = 0;
            end
        end
    end

    always @(negedge clk) begin
        logic       idle, run;
        logic [7:0] act, exp, mask;
        if (cyc > 0) begin
            for (int i = 0; i < 2; i++) begin
                idle = !m_busy[i] && !m_done[i];
                run  = m_busy[i];
                exp  = {!reset && idle,
                        !reset && m_done[i],
                        !reset && (idle || run),
                        !reset && (idle || run),
                        !reset && (idle || (run && b_lsb === 1'b1)),
                        idle, idle, idle};
                act  = {irdy[i], oval[i], aen[i], ben[i], ren[i], asel[i], bsel[i], rsel[i]};
                mask = m_done[i] ? 8'hF8 : 8'hFF;
                chk(i == 0 ? "cycle_fix" : "cycle_ee", 32'(act & mask), 32'(exp & mask));
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    int low_cnt, ren_cnt, ren_k, first_fix, first_ee, oval_cnt, en_dn, tmp;
    int acc[$];

    initial begin
        // Reset state
        repeat (2) next();
        @(negedge clk);
        chk("reset_rdy", 32'(irdy), 32'd0);
        chk("reset_oval", 32'(oval), 32'd0);
        chk("reset_en", 32'({aen, ben, ren}), 32'd0);
        chk("reset_sel", 32'({asel, bsel, rsel}), 32'h3F);
        next();
        reset = 1'b0;
        next();
        @(negedge clk);
        chk("idle_rdy", 32'(irdy), 32'h3);
        chk("idle_en", 32'({aen, ben, ren}), 32'h3F);

        // Fixed latency with a single b_lsb pulse, then 5 cycles of backpressure
        next();
        istream_val = 1'b1;
        next();
        istream_val = 1'b0;
        low_cnt = 0; ren_cnt = 0; ren_k = 0; first_fix = 0; oval_cnt = 0; en_dn = 0; tmp = 0;
        for (int k = 1; k <= 39; k++) begin
            b_lsb = (k == 3);
            ostream_rdy = (k >= 38);
            @(negedge clk);
            if (k < 33 && !irdy[0]) low_cnt++;
            if (k <= 38 && ren[0]) begin ren_cnt++; ren_k = k; end
            if (oval[0] && first_fix == 0) first_fix = k;
            if (oval[0]) oval_cnt++;
            if (k >= 33 && k <= 38 && (aen[0] | ben[0] | ren[0])) en_dn++;
            if (k == 39) tmp = int'(irdy[0]);
            next();
        end
        b_lsb = 1'b0;
        chk("calc_rdy_low", 32'(low_cnt), 32'd32);
        chk("ren_count", 32'(ren_cnt), 32'd1);
        chk("ren_cycle", 32'(ren_k), 32'd3);
        chk("oval_first", 32'(first_fix), 32'd33);
        chk("oval_held", 32'(oval_cnt), 32'd6);
        chk("done_en_off", 32'(en_dn), 32'd0);
        chk("idle_after_hs", 32'(tmp), 32'd1);

        // Back-to-back with both streams always ready
        istream_val = 1'b1;
        ostream_rdy = 1'b1;
        tmp = 0;
        for (int k = 0; k < 120; k++) begin
            b_lsb = 1'($urandom);
            @(negedge clk);
            if (irdy[0]) acc.push_back(k);
            if (oval[0] && irdy[0]) tmp++;
            next();
        end
        chk("b2b_accepts", 32'(acc.size()), 32'd4);
        for (int j = 1; j < acc.size(); j++) chk("b2b_gap", 32'(acc[j] - acc[j-1]), 32'd34);
        chk("b2b_done_rdy", 32'(tmp), 32'd0);
        istream_val = 1'b0;
        b_lsb = 1'b0;
        repeat (40) next();

        // Early exit on b_zero in the first CALC cycle
        istream_val = 1'b1;
        next();
        istream_val = 1'b0;
        first_fix = 0; first_ee = 0;
        for (int k = 1; k <= 35; k++) begin
            b_zero = (k == 1);
            @(negedge clk);
            if (oval[0] && first_fix == 0) first_fix = k;
            if (oval[1] && first_ee == 0) first_ee = k;
            next();
        end
        b_zero = 1'b0;
        chk("ee_first_oval", 32'(first_ee), 32'd2);
        chk("fix_first_oval", 32'(first_fix), 32'd33);

        // Reset mid-CALC at counter 10, then a fresh full transaction
        istream_val = 1'b1;
        next();
        istream_val = 1'b0;
        repeat (10) next();
        reset = 1'b1;
        @(negedge clk);
        chk("rst_calc_out", 32'({irdy, oval, aen, ben, ren}), 32'd0);
        next();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_calc_idle", 32'({irdy, oval}), 32'hC);
        tmp = 0;
        for (int k = 0; k < 40; k++) begin
            b_lsb = 1'bx;
            b_zero = 1'bx;
            next();
            @(negedge clk);
            if (oval !== 2'b00) tmp++;
        end
        chk("abort_no_oval", 32'(tmp), 32'd0);
        b_lsb = 1'b0;
        b_zero = 1'b0;
        next();
        istream_val = 1'b1;
        next();
        istream_val = 1'b0;
        first_fix = 0; tmp = 0;
        for (int k = 1; k <= 34; k++) begin
            @(negedge clk);
            if (oval[0] && first_fix == 0) first_fix = k;
            if (k == 34) tmp = int'(irdy[0]);
            next();
        end
        chk("post_rst_oval", 32'(first_fix), 32'd33);
        chk("post_rst_idle", 32'(tmp), 32'd1);

        // Reset while holding the product with the consumer ready
        istream_val = 1'b1;
        next();
        istream_val = 1'b0;
        ostream_rdy = 1'b0;
        repeat (32) next();
        @(negedge clk);
        chk("done_reached", 32'(oval), 32'h3);
        next();
        reset = 1'b1;
        ostream_rdy = 1'b1;
        @(negedge clk);
        chk("rst_done_oval", 32'({oval, irdy}), 32'd0);
        next();
        reset = 1'b0;
        @(negedge clk);
        chk("rst_done_idle", 32'({irdy, oval}), 32'hC);
        repeat (3) next();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

endmodule
